demux6ne1_reg: RTL
==================

Name: demux6ne1_reg

Overview:
- Registered 1-to-6 demultiplexer with a valid/ready handshake; the write-side counterpart of the 6-to-1 operand mux.
- Takes one WIDTH-bit result plus a 3-bit destination select and routes it to one of six sink ports.
- Holds the word until the selected sink accepts it.
- Sits between the ALU/result bus and the six destination registers/units of the 24-bit CPU datapath.

Parameters:
- WIDTH, 24, data width of the input and of each output lane.
- CNT_W, 8, width of the illegal-select drop counter.

Ports:
- Clock  input  1  system clock; all state updates on its rising edge.
- Reset_n  input  1  synchronous, active-low reset; sampled on the rising edge of Clock.
- Hyrja  input  WIDTH  data word to route.
- S  input  3  destination select, sampled together with Hyrja.
- Hyrja_valid  input  1  upstream has a word on Hyrja/S.
- Hyrja_ready  output  1  block can accept a word this cycle.
- Dalja0..Dalja5  output  WIDTH each  per-lane data registers.
- Dalja_valid  output  6  one-hot; bit k set while lane k holds an unaccepted word.
- Dalja_ready  input  6  per-lane sink acceptance.
- Gabim  output  1  one-cycle pulse when a word with an illegal select is dropped.
- Gabim_cnt  output  CNT_W  saturating count of dropped words.

Behaviour:
- Reset (Reset_n=0 at a rising edge):
  - Dalja0..5=0, Dalja_valid=0, Gabim=0, Gabim_cnt=0.
  - FSM goes to IDLE; Hyrja_ready=1 in the cycle after reset.
  - Reset mid-HOLD discards the pending word with no sink handshake.
- Select decode is fixed: 000->lane0, 001->lane1, 010->lane2, 011->lane3, 100->lane4, 101->lane5. 110 and 111 are illegal.
- Transfer rules:
  - An input transfer occurs when Hyrja_valid & Hyrja_ready.
  - An output transfer on lane k occurs when Dalja_valid[k] & Dalja_ready[k].
- FSM states: IDLE, HOLD.
- IDLE:
  - Hyrja_ready=1.
  - Input transfer with legal S: Dalja<lane> <= Hyrja, Dalja_valid <= onehot(lane), dest register <= lane; next state HOLD.
  - Input transfer with illegal S: word dropped; Gabim=1 on the next cycle only; Gabim_cnt increments, saturating at 2^CNT_W-1 without wrapping. State stays IDLE.
- HOLD:
  - Hyrja_ready=0, unless DEMUX_PASSTHRU_EN is defined (see below).
  - Dalja_valid[dest] stays 1 and Dalja<dest> stays stable until Dalja_ready[dest]=1.
  - On that output transfer: Dalja_valid <= 0, next state IDLE.
  - Dalja_ready on non-selected lanes is ignored.
- Latency: data is visible on Dalja_valid one cycle after the input transfer edge. Minimum two cycles per word without the optional feature.
- Data retention: non-selected lanes keep their last written value; lane data is never cleared except by reset.
- Dalja_valid is at most one-hot at all times.
- Hyrja_ready depends only on state, and on Dalja_ready when the optional feature is defined. It never depends on Hyrja_valid.
- Upstream may hold Hyrja_valid high with changing data while Hyrja_ready=0; nothing is captured.

Optional Feature:
- Macro: DEMUX_PASSTHRU_EN.
- Defined:
  - In HOLD, Hyrja_ready = Dalja_ready[dest].
  - When an output transfer and an input transfer occur in the same cycle, the new word is captured in place:
    - Legal S: Dalja_valid <= onehot(new lane), state stays HOLD.
    - Illegal S: drop and Gabim pulse as in IDLE, and state goes to IDLE.
  - Sustained throughput is one word per cycle.
  - If the new lane equals the old lane, the lane register is overwritten and valid stays 1.
- Undefined: HOLD always drives Hyrja_ready=0; one bubble cycle per word.

Test Plan:
- Reset: hold Reset_n=0 for 2 cycles with Hyrja_valid=1 -> all Dalja=0, Dalja_valid=0, Gabim_cnt=0; Hyrja_ready=1 after release.
- Lane sweep: send 0x000011..0x000066 with S=000..101, Dalja_ready=6'h3F -> each lane k ends with 0x0000(k+1)(k+1); Dalja_valid pulses bits 0..5 in order; other lanes unchanged.
- Backpressure: S=011, Hyrja=0xABCDEF, Dalja_ready=0 for 5 cycles, then Dalja_ready[3]=1 -> Dalja_valid=6'b001000 and Dalja3 stable for 5 cycles; Hyrja_ready=0 throughout (macro off); valid clears after the accepting edge.
- Illegal select: S=110 then S=111, with Hyrja_valid=1 for 1 cycle each -> two Gabim pulses, Gabim_cnt=2, Dalja_valid stays 0; preset counter to 255 -> it stays 255.
- Reset mid-HOLD: lane 2 pending, Reset_n=0 for 1 cycle -> Dalja_valid=0, Dalja2=0, state IDLE.
- Passthrough (macro on): stream 8 words round-robin to lanes 0..5 with Dalja_ready=6'h3F -> 8 words in 9 cycles; same-lane back-to-back writes keep valid high with updated data.

Source files
------------

// File: rtl/demux6ne1_reg.sv
// Registered 1-to-6 demultiplexer with valid/ready handshake and illegal-select drop counter.
// Define DEMUX_PASSTHRU_EN to accept a new word in the same cycle the held word is taken.
module demux6ne1_reg #(
   parameter int unsigned WIDTH = 24,
   parameter int unsigned CNT_W = 8
) (
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic [WIDTH-1:0] Hyrja,
   input  logic [2:0]       S,
   input  logic             Hyrja_valid,
   output logic             Hyrja_ready,
   output logic [WIDTH-1:0] Dalja0,
   output logic [WIDTH-1:0] Dalja1,
   output logic [WIDTH-1:0] Dalja2,
   output logic [WIDTH-1:0] Dalja3,
   output logic [WIDTH-1:0] Dalja4,
   output logic [WIDTH-1:0] Dalja5,
   output logic [5:0]       Dalja_valid,
   input  logic [5:0]       Dalja_ready,
   output logic             Gabim,
   output logic [CNT_W-1:0] Gabim_cnt
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t           state_q;
   logic [2:0]       dest_q;
   logic [WIDTH-1:0] dalja_q [6];
   logic [5:0]       valid_q;
   logic             gabim_q;
   logic [CNT_W-1:0] cnt_q;

   logic       ready_sel;
   logic       out_xfer;
   logic       in_xfer;
   logic       legal;
   logic [5:0] onehot_d;

   always_comb begin
      ready_sel = 1'b0;
      for (int unsigned k = 0; k < 6; k++) begin
         if (dest_q == 3'(k)) ready_sel = Dalja_ready[k];
      end
   end

   assign out_xfer = (state_q == HOLD) & ready_sel;

`ifdef DEMUX_PASSTHRU_EN
   assign Hyrja_ready = (state_q == IDLE) | ready_sel;
`else
   assign Hyrja_ready = (state_q == IDLE);
`endif

   assign in_xfer  = Hyrja_valid & Hyrja_ready;
   assign legal    = (S <= 3'd5);
   assign onehot_d = legal ? (6'b000001 << S) : '0;

   // An input transfer while in HOLD only happens together with out_xfer, so the
   // out_xfer release below is what sends an illegal passthrough word back to IDLE.
   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         dest_q  <= '0;
         valid_q <= '0;
         gabim_q <= 1'b0;
         cnt_q   <= '0;
         for (int unsigned k = 0; k < 6; k++) dalja_q[k] <= '0;
      end else begin
         gabim_q <= 1'b0;
         if (out_xfer) begin
            valid_q <= '0;
            state_q <= IDLE;
         end
         if (in_xfer) begin
            if (legal) begin
               for (int unsigned k = 0; k < 6; k++) begin
                  if (S == 3'(k)) dalja_q[k] <= Hyrja;
               end
               valid_q <= onehot_d;
               dest_q  <= S;
               state_q <= HOLD;
            end else begin
               gabim_q <= 1'b1;
               if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   end

   assign Dalja0      = dalja_q[0];
   assign Dalja1      = dalja_q[1];
   assign Dalja2      = dalja_q[2];
   assign Dalja3      = dalja_q[3];
   assign Dalja4      = dalja_q[4];
   assign Dalja5      = dalja_q[5];
   assign Dalja_valid = valid_q;
   assign Gabim       = gabim_q;
   assign Gabim_cnt   = cnt_q;

endmodule
